smu_cfg_loader: RTL

Serial configuration loader that writes the SMU's comparison registers (mask, compare value, compare select, FSM target state) and drives the SMU enable. It accepts a bit-serial configuration stream with a valid/ready handshake and assembles it in a shadow register. It commits all fields atomically and asserts smu_en only once the full bitstream has been loaded. It sits between the patch configuration interface and each smu_unit instance.

---
 rtl/smu_cfg_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/smu_cfg_loader.sv
// Bit-serial configuration loader for one SMU: shifts a valid/ready stream into a shadow
// register and commits mask/compare/select/FSM target atomically. Optional parity: SMU_CFG_PARITY_EN.
module smu_cfg_loader #(
    parameter int N = 2,
    parameter int K = 4,
    localparam int FSM_W = $clog2(N),
    localparam int CFG_W = 2*K + 2 + FSM_W,
    localparam int CNT_W = $clog2(CFG_W + 1)
) (
    input  logic             gated_clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_clear,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic [K-1:0]     reg_cmp_mask,
    output logic [K-1:0]     reg_cmp,
    output logic [1:0]       reg_cmp_select,
    output logic [FSM_W-1:0] reg_fsm_cmp,
    output logic             smu_en,
    output logic             cfg_done,
    output logic             cfg_busy,
    output logic             cfg_err,
    output logic [CNT_W-1:0] bit_cnt
);

`ifdef SMU_CFG_PARITY_EN
    localparam int FRAME_W = CFG_W + 1;
`else
    localparam int FRAME_W = CFG_W;
`endif
    // The final beat of a frame is consumed straight into the commit, so it needs no shadow bit.
    localparam int SHADOW_W = FRAME_W - 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
`ifdef SMU_CFG_PARITY_EN
        ARMED = 2'd2,
        ERROR = 2'd3
`else
        ARMED = 2'd2
`endif
    } state_t;

    state_t                state_reg, state_next;
    logic [SHADOW_W-1:0]   shadow_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [K-1:0]          mask_reg, cmp_reg;
    logic [1:0]            sel_reg;
    logic [FSM_W-1:0]      fsm_reg;
    logic                  done_reg;
    logic                  beat, last_beat, commit_ok;
    logic [CFG_W-1:0]      commit_frame;

    assign cfg_ready = (state_reg == LOAD) && !cfg_start && !cfg_clear;
    assign beat      = cfg_valid && cfg_ready;
    assign last_beat = beat && (bit_cnt_reg == LAST_IDX);

`ifdef SMU_CFG_PARITY_EN
    logic err_reg;
    logic parity_bad;
    assign commit_frame = shadow_reg;
    assign parity_bad   = last_beat && ((^shadow_reg) ^ cfg_bit);
    assign commit_ok    = last_beat && !parity_bad;
    assign cfg_err      = err_reg;
`else
    assign commit_frame = {cfg_bit, shadow_reg};
    assign commit_ok    = last_beat;
    assign cfg_err      = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        if (cfg_clear)
            state_next = IDLE;
        else if (cfg_start)
            state_next = LOAD;
        else if (commit_ok)
            state_next = ARMED;
`ifdef SMU_CFG_PARITY_EN
        else if (parity_bad)
            state_next = ERROR;
`endif
    end

    always_ff @(posedge gated_clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    generate
        for (genvar gi = 0; gi < SHADOW_W; gi++) begin : g_shadow
            always_ff @(posedge gated_clk) begin
                if (reset || cfg_clear || cfg_start)
                    shadow_reg[gi] <= 1'b0;
                else if (beat && (bit_cnt_reg == CNT_W'(gi)))
                    shadow_reg[gi] <= cfg_bit;
            end
        end
    endgenerate

    always_ff @(posedge gated_clk) begin
        if (reset) begin
            bit_cnt_reg <= '0;
            mask_reg    <= '0;
            cmp_reg     <= '0;
            sel_reg     <= '0;
            fsm_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= commit_ok;
            if (cfg_clear) begin
                bit_cnt_reg <= '0;
                mask_reg    <= '0;
                cmp_reg     <= '0;
                sel_reg     <= '0;
                fsm_reg     <= '0;
            end else if (cfg_start) begin
                bit_cnt_reg <= '0;
            end else if (beat) begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                // All fields update on the same edge so no partial config is ever visible.
                if (commit_ok) begin
                    mask_reg <= commit_frame[K-1:0];
                    cmp_reg  <= commit_frame[2*K-1:K];
                    sel_reg  <= commit_frame[2*K+1:2*K];
                    fsm_reg  <= commit_frame[CFG_W-1:2*K+2];
                end
            end
        end
    end

`ifdef SMU_CFG_PARITY_EN
    always_ff @(posedge gated_clk) begin
        if (reset || cfg_clear || cfg_start)
            err_reg <= 1'b0;
        else if (parity_bad)
            err_reg <= 1'b1;
    end
`endif

    assign reg_cmp_mask   = mask_reg;
    assign reg_cmp        = cmp_reg;
    assign reg_cmp_select = sel_reg;
    assign reg_fsm_cmp    = fsm_reg;
    assign smu_en         = (state_reg == ARMED);
    assign cfg_busy       = (state_reg == LOAD);
    assign cfg_done       = done_reg;
    assign bit_cnt        = bit_cnt_reg;

endmodule
